cu_param: RTL

Parametrised multi-cycle control unit for the accumulator microprocessor. It has a configurable data width, PC width and register-file depth. It fetches instructions over a request/acknowledge instruction-memory port that tolerates wait states, and it supports run/pause, halt and illegal-opcode reporting. It is the next generation of the fixed 8-bit CU and keeps its three debug outputs for the top-level bench.

---
 rtl/cu_param_if.sv | 20 ++
 rtl/cu_param.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cu_param_if.sv
`default_nettype none
// ============================================================================
// Module      : cu_param_if
// Description : Instruction-memory request/acknowledge port of cu_param.
//               The control unit is the master; the memory is the slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface cu_param_if #(
   parameter int PC_W = 8,
   parameter int IW   = 14
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack;
   logic [IW-1:0]   imem_data;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface
`default_nettype wire

// File: rtl/cu_param.sv
`default_nettype none
// ============================================================================
// Module      : cu_param
// Description : Parametrised multi-cycle control unit for the accumulator
//               processor. Fetches over a req/ack port with wait states,
//               supports run/pause, halt and illegal-opcode reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module cu_param #(
   parameter int  DATA_W = 8,
   parameter int  PC_W   = 8,
   parameter int  NREG   = 4,
   localparam int RSEL_W = $clog2(NREG),
   localparam int IW     = 4 + RSEL_W + DATA_W
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              run,
   cu_param_if.master             imem,
   input  wire logic [RSEL_W-1:0] dbg_sel,
   output logic                   halted,
   output logic                   illegal,
   output logic                   zflag,
   output logic                   cflag,
   output logic [DATA_W-1:0]      debug,
   output logic [DATA_W-1:0]      debug1,
   output logic [DATA_W-1:0]      debug2
);

   localparam logic [3:0] c_OP_NOP  = 4'h0;
   localparam logic [3:0] c_OP_LDI  = 4'h1;
   localparam logic [3:0] c_OP_MOV  = 4'h2;
   localparam logic [3:0] c_OP_LDR  = 4'h3;
   localparam logic [3:0] c_OP_ADD  = 4'h4;
   localparam logic [3:0] c_OP_SUB  = 4'h5;
   localparam logic [3:0] c_OP_AND  = 4'h6;
   localparam logic [3:0] c_OP_OR   = 4'h7;
   localparam logic [3:0] c_OP_XOR  = 4'h8;
   localparam logic [3:0] c_OP_ADDI = 4'h9;
   localparam logic [3:0] c_OP_JMP  = 4'hA;
   localparam logic [3:0] c_OP_JZ   = 4'hB;
   localparam logic [3:0] c_OP_JC   = 4'hC;
   localparam logic [3:0] c_OP_HLT  = 4'hD;
   localparam logic [3:0] c_OP_IL0  = 4'hE;
   localparam logic [3:0] c_OP_IL1  = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t              r_state;
   logic [IW-1:0]       r_ir;
   logic [PC_W-1:0]     r_pc;
   logic [DATA_W-1:0]   r_acc;
   logic [DATA_W-1:0]   r_regs [NREG];
   logic                r_z;
   logic                r_c;
   logic                r_halted;
   logic                r_illegal;

   logic [3:0]          w_op;
   logic [RSEL_W-1:0]   w_rs;
   logic [DATA_W-1:0]   w_imm;
   logic [DATA_W-1:0]   w_rval;
   logic [DATA_W-1:0]   w_opnd;
   logic [DATA_W:0]     w_add;
   logic [DATA_W:0]     w_sub;
   logic [PC_W-1:0]     w_jtgt;

   logic [DATA_W-1:0]   w_res;
   logic                w_wr_acc;
   logic                w_wr_reg;
   logic                w_upd_z;
   logic                w_upd_c;
   logic                w_cout;
   logic                w_jump;
   logic                w_hlt;
   logic                w_ill;

   // Instruction fields; op occupies the MSBs, imm the LSBs
   assign w_op   = r_ir[IW-1 -: 4];
   assign w_rs   = r_ir[DATA_W +: RSEL_W];
   assign w_imm  = r_ir[DATA_W-1:0];
   assign w_rval = r_regs[w_rs];

   // One adder serves ADD and ADDI; the extra MSB is the carry / borrow
   assign w_opnd = (w_op == c_OP_ADDI) ? w_imm : w_rval;
   assign w_add  = {1'b0, r_acc} + {1'b0, w_opnd};
   assign w_sub  = {1'b0, r_acc} - {1'b0, w_rval};

   // Jump target: low PC_W bits of imm, zero-extended when PC is wider
   generate
      if (PC_W <= DATA_W) begin : g_jtgt_trunc
         assign w_jtgt = w_imm[PC_W-1:0];
      end else begin : g_jtgt_zext
         assign w_jtgt = {{(PC_W-DATA_W){1'b0}}, w_imm};
      end
   endgenerate

   // PC onto debug1, zero-extended or truncated to DATA_W
   generate
      if (PC_W >= DATA_W) begin : g_dbg1_trunc
         assign debug1 = r_pc[DATA_W-1:0];
      end else begin : g_dbg1_zext
         assign debug1 = {{(DATA_W-PC_W){1'b0}}, r_pc};
      end
   endgenerate

   // Execute-stage decode: result value and which state elements it updates
   always_comb begin
      w_res    = r_acc;
      w_wr_acc = 1'b0;
      w_wr_reg = 1'b0;
      w_upd_z  = 1'b0;
      w_upd_c  = 1'b0;
      w_cout   = r_c;
      w_jump   = 1'b0;
      w_hlt    = 1'b0;
      w_ill    = 1'b0;
      case (w_op)
         c_OP_NOP  : ;
         c_OP_LDI  : begin w_res = w_imm;                 w_wr_acc = 1'b1; w_upd_z = 1'b1; end
         c_OP_MOV  : w_wr_reg = 1'b1;
         c_OP_LDR  : begin w_res = w_rval;                w_wr_acc = 1'b1; w_upd_z = 1'b1; end
         c_OP_ADD,
         c_OP_ADDI : begin
            w_res    = w_add[DATA_W-1:0];
            w_cout   = w_add[DATA_W];
            w_wr_acc = 1'b1;
            w_upd_z  = 1'b1;
            w_upd_c  = 1'b1;
         end
         c_OP_SUB  : begin
            w_res    = w_sub[DATA_W-1:0];
            w_cout   = w_sub[DATA_W];
            w_wr_acc = 1'b1;
            w_upd_z  = 1'b1;
            w_upd_c  = 1'b1;
         end
         c_OP_AND  : begin w_res = r_acc & w_rval;        w_wr_acc = 1'b1; w_upd_z = 1'b1; end
         c_OP_OR   : begin w_res = r_acc | w_rval;        w_wr_acc = 1'b1; w_upd_z = 1'b1; end
         c_OP_XOR  : begin w_res = r_acc ^ w_rval;        w_wr_acc = 1'b1; w_upd_z = 1'b1; end
         c_OP_JMP  : w_jump = 1'b1;
         c_OP_JZ   : w_jump = r_z;
         c_OP_JC   : w_jump = r_c;
         c_OP_HLT  : w_hlt  = 1'b1;
         c_OP_IL0,
         c_OP_IL1  : w_ill  = 1'b1;
         default   : ;
      endcase
   end

   // Control FSM plus all architectural state; reset abandons any fetch in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ir      <= '0;
         r_pc      <= '0;
         r_acc     <= '0;
         r_z       <= 1'b0;
         r_c       <= 1'b0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (run) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (imem.imem_ack) begin
                  r_ir    <= imem.imem_data;
                  r_pc    <= r_pc + PC_W'(1);
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_wr_acc) r_acc          <= w_res;
               if (w_upd_z)  r_z            <= (w_res == '0);
               if (w_upd_c)  r_c            <= w_cout;
               if (w_wr_reg) r_regs[w_rs]   <= r_acc;
               if (w_jump)   r_pc           <= w_jtgt;
               if (w_ill)    r_illegal      <= 1'b1;
               if (w_hlt) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (run) begin
                  r_state  <= S_FETCH;
               end else begin
                  r_state  <= S_IDLE;
               end
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Fetch request follows the state directly so the address is held until ack
   assign imem.imem_req  = (r_state == S_FETCH);
   assign imem.imem_addr = r_pc;

   assign halted  = r_halted;
   assign illegal = r_illegal;
   assign zflag   = r_z;
   assign cflag   = r_c;
   assign debug   = r_acc;
   assign debug2  = r_regs[dbg_sel];

endmodule
`default_nettype wire
